// File: rtl/toy_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : toy_wb_write_arbiter
// Brief    : Buffers results from SRC_NUM sources in 2-entry FIFOs and issues
//            up to EU_NUM of them per cycle, round-robin, on the regfile
//            write-port bus.
// Revision : 1.0
// ============================================================================
module toy_wb_write_arbiter #(
    parameter int SRC_NUM          = 12,
    parameter int EU_NUM           = 10,
    parameter int PHY_REG_ID_WIDTH = 7,
    parameter int REG_WIDTH        = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [SRC_NUM-1:0]                   v_src_valid,
    output logic [SRC_NUM-1:0]                   v_src_ready,
    input  logic [SRC_NUM-1:0]                   v_src_fp,
    input  logic [SRC_NUM*PHY_REG_ID_WIDTH-1:0]  v_src_reg_index,
    input  logic [SRC_NUM*REG_WIDTH-1:0]         v_src_reg_data,
    output logic [EU_NUM-1:0]                    v_int_wr_en,
    output logic [EU_NUM-1:0]                    v_fp_wr_en,
    output logic [EU_NUM*PHY_REG_ID_WIDTH-1:0]   v_wr_reg_index,
    output logic [EU_NUM*REG_WIDTH-1:0]          v_wr_reg_data,
    output logic                                 conflict_err
);

    localparam int c_ENT_W  = 1 + PHY_REG_ID_WIDTH + REG_WIDTH;
    localparam int c_KEY_W  = 1 + PHY_REG_ID_WIDTH;
    localparam int c_PTR_W  = $clog2(SRC_NUM);
    localparam int c_PORT_W = $clog2(EU_NUM + 1);

    // Entry layout: {fp, index, data}; slot 0 is always the FIFO head.
    logic [c_ENT_W-1:0]                r_ent   [SRC_NUM][2];
    logic [1:0]                        r_count [SRC_NUM];
    logic [c_PTR_W-1:0]                r_rr_ptr;
    logic [EU_NUM-1:0]                 r_int_wr_en;
    logic [EU_NUM-1:0]                 r_fp_wr_en;
    logic [EU_NUM*PHY_REG_ID_WIDTH-1:0] r_wr_reg_index;
    logic [EU_NUM*REG_WIDTH-1:0]       r_wr_reg_data;
    logic                              r_conflict_err;

    logic [c_ENT_W-1:0]                w_new   [SRC_NUM];
    logic [c_ENT_W-1:0]                w_head  [EU_NUM];
    logic [c_PTR_W-1:0]                w_port_src [EU_NUM];
    logic [EU_NUM-1:0]                 w_port_vld;
    logic [SRC_NUM-1:0]                w_push;
    logic [SRC_NUM-1:0]                w_grant;
    logic [c_PTR_W-1:0]                w_last;
    logic [c_PTR_W:0]                  w_sum;
    logic [c_PTR_W-1:0]                w_scan;
    logic [c_PORT_W-1:0]               w_n;
    logic                              w_conflict;

    // Ready depends only on registered occupancy, never on valid or grant.
    always_comb begin
        for (int s = 0; s < SRC_NUM; s++) begin
            v_src_ready[s] = ~rst & (r_count[s] != 2'd2);
            w_push[s]      = v_src_valid[s] & v_src_ready[s];
            w_new[s]       = {v_src_fp[s],
                              v_src_reg_index[s*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH],
                              v_src_reg_data[s*REG_WIDTH +: REG_WIDTH]};
        end
    end

    always_comb begin
        w_grant    = '0;
        w_port_vld = '0;
        w_last     = r_rr_ptr;
        w_sum      = '0;
        w_scan     = '0;
        w_n        = '0;
        for (int k = 0; k < EU_NUM; k++) begin
            w_port_src[k] = '0;
        end
        for (int i = 0; i < SRC_NUM; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(i);
            if (w_sum >= (c_PTR_W+1)'(SRC_NUM)) begin
                w_sum = w_sum - (c_PTR_W+1)'(SRC_NUM);
            end
            w_scan = w_sum[c_PTR_W-1:0];
            if ((r_count[w_scan] != 2'd0) && (w_n < c_PORT_W'(EU_NUM))) begin
                w_grant[w_scan]     = 1'b1;
                w_port_vld[w_n]     = 1'b1;
                w_port_src[w_n]     = w_scan;
                w_last              = w_scan;
                w_n                 = w_n + c_PORT_W'(1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < EU_NUM; k++) begin
            w_head[k] = r_ent[w_port_src[k]][0];
        end
        w_conflict = 1'b0;
        for (int i = 0; i < EU_NUM; i++) begin
            for (int j = i + 1; j < EU_NUM; j++) begin
                if (w_port_vld[i] && w_port_vld[j] &&
                    (w_head[i][c_ENT_W-1 -: c_KEY_W] == w_head[j][c_ENT_W-1 -: c_KEY_W])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SRC_NUM; s++) begin
                r_count[s]  <= 2'd0;
                r_ent[s][0] <= '0;
                r_ent[s][1] <= '0;
            end
        end else begin
            for (int s = 0; s < SRC_NUM; s++) begin
                case ({w_push[s], w_grant[s]})
                    2'b10: begin
                        r_ent[s][r_count[s][0]] <= w_new[s];
                        r_count[s]              <= r_count[s] + 2'd1;
                    end
                    2'b01: begin
                        r_ent[s][0] <= r_ent[s][1];
                        r_count[s]  <= r_count[s] - 2'd1;
                    end
                    2'b11: begin
                        // Occupancy stays put; the new entry lands behind whatever survives the pop.
                        if (r_count[s] == 2'd1) begin
                            r_ent[s][0] <= w_new[s];
                        end else begin
                            r_ent[s][0] <= r_ent[s][1];
                            r_ent[s][1] <= w_new[s];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_wr_en    <= '0;
            r_fp_wr_en     <= '0;
            r_wr_reg_index <= '0;
            r_wr_reg_data  <= '0;
            r_conflict_err <= 1'b0;
            r_rr_ptr       <= '0;
        end else begin
            for (int k = 0; k < EU_NUM; k++) begin
                if (w_port_vld[k]) begin
                    r_int_wr_en[k] <= ~w_head[k][c_ENT_W-1];
                    r_fp_wr_en[k]  <= w_head[k][c_ENT_W-1];
                    r_wr_reg_index[k*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH] <=
                        w_head[k][REG_WIDTH +: PHY_REG_ID_WIDTH];
                    r_wr_reg_data[k*REG_WIDTH +: REG_WIDTH] <= w_head[k][REG_WIDTH-1:0];
                end else begin
                    r_int_wr_en[k] <= 1'b0;
                    r_fp_wr_en[k]  <= 1'b0;
                    r_wr_reg_index[k*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH] <= '0;
                    r_wr_reg_data[k*REG_WIDTH +: REG_WIDTH] <= '0;
                end
            end
            r_conflict_err <= r_conflict_err | w_conflict;
            // Resume just past the last winner so skipped sources lead next cycle.
            if (|w_grant) begin
                r_rr_ptr <= (w_last == c_PTR_W'(SRC_NUM - 1)) ? '0 : w_last + c_PTR_W'(1);
            end
        end
    end

    assign v_int_wr_en    = r_int_wr_en;
    assign v_fp_wr_en     = r_fp_wr_en;
    assign v_wr_reg_index = r_wr_reg_index;
    assign v_wr_reg_data  = r_wr_reg_data;
    assign conflict_err   = r_conflict_err;

endmodule
`default_nettype wire

// File: tb/tb_toy_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_toy_wb_write_arbiter
// Brief    : Scoreboard bench for toy_wb_write_arbiter with directed scenarios.
// Revision : 1.0
// ============================================================================
module tb_toy_wb_write_arbiter;

    localparam int c_SRC = 12;
    localparam int c_EU  = 10;
    localparam int c_IW  = 7;
    localparam int c_DW  = 64;
    localparam int c_EW  = 1 + c_IW + c_DW;

    typedef logic [c_EW-1:0] ent_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [c_SRC-1:0]        v_src_valid = '0;
    logic [c_SRC-1:0]        v_src_ready;
    logic [c_SRC-1:0]        v_src_fp = '0;
    logic [c_SRC*c_IW-1:0]   v_src_reg_index = '0;
    logic [c_SRC*c_DW-1:0]   v_src_reg_data = '0;
    logic [c_EU-1:0]         v_int_wr_en;
    logic [c_EU-1:0]         v_fp_wr_en;
    logic [c_EU*c_IW-1:0]    v_wr_reg_index;
    logic [c_EU*c_DW-1:0]    v_wr_reg_data;
    logic                    conflict_err;

    ent_t pend_q [c_SRC][$];
    ent_t exp_q  [c_SRC][$];
    int   errors    = 0;
    int   checks    = 0;
    int   delivered = 0;
    bit   seen_rdy2_low = 1'b0;

    toy_wb_write_arbiter #(
        .SRC_NUM(c_SRC), .EU_NUM(c_EU), .PHY_REG_ID_WIDTH(c_IW), .REG_WIDTH(c_DW)
    ) dut (
        .clk(clk), .rst(rst),
        .v_src_valid(v_src_valid), .v_src_ready(v_src_ready), .v_src_fp(v_src_fp),
        .v_src_reg_index(v_src_reg_index), .v_src_reg_data(v_src_reg_data),
        .v_int_wr_en(v_int_wr_en), .v_fp_wr_en(v_fp_wr_en),
        .v_wr_reg_index(v_wr_reg_index), .v_wr_reg_data(v_wr_reg_data),
        .conflict_err(conflict_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input logic fp, input int idx, input logic [63:0] d);
        return {fp, c_IW'(idx), d};
    endfunction

    function automatic logic [c_IW-1:0] out_idx(input int k);
        return v_wr_reg_index[k*c_IW +: c_IW];
    endfunction

    function automatic logic [c_DW-1:0] out_data(input int k);
        return v_wr_reg_data[k*c_DW +: c_DW];
    endfunction

    function automatic bit queues_empty();
        for (int s = 0; s < c_SRC; s++) begin
            if (pend_q[s].size() != 0 || exp_q[s].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Driver: present each source's pending head just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < c_SRC; s++) begin
                if (pend_q[s].size() > 0) begin
                    v_src_valid[s] = 1'b1;
                    {v_src_fp[s], v_src_reg_index[s*c_IW +: c_IW], v_src_reg_data[s*c_DW +: c_DW]} = pend_q[s][0];
                end else begin
                    v_src_valid[s] = 1'b0;
                    v_src_fp[s]    = 1'b0;
                    v_src_reg_index[s*c_IW +: c_IW] = '0;
                    v_src_reg_data[s*c_DW +: c_DW]  = '0;
                end
            end
        end
    end

    // Monitor: match writes against per-source expected heads, then log handshakes.
    initial begin
        forever begin
            ent_t e;
            bit   found;
            @(negedge clk);
            for (int k = 0; k < c_EU; k++) begin
                if (v_int_wr_en[k] || v_fp_wr_en[k]) begin
                    check_eq("port_en_excl", 64'(v_int_wr_en[k] & v_fp_wr_en[k]), 64'd0);
                    e = {v_fp_wr_en[k], out_idx(k), out_data(k)};
                    found = 1'b0;
                    for (int s = 0; s < c_SRC; s++) begin
                        if (!found && exp_q[s].size() > 0 && exp_q[s][0] == e) begin
                            found = 1'b1;
                            void'(exp_q[s].pop_front());
                            delivered++;
                        end
                    end
                    check_eq("sb_write", 64'(found), 64'd1);
                end else begin
                    check_eq("idle_port", 64'(out_idx(k) == '0 && out_data(k) == '0), 64'd1);
                end
            end
            for (int s = 0; s < c_SRC; s++) begin
                if (v_src_valid[s] && v_src_ready[s] && pend_q[s].size() > 0) begin
                    exp_q[s].push_back(pend_q[s].pop_front());
                end
            end
            if (!rst && !v_src_ready[2]) seen_rdy2_low = 1'b1;
        end
    end

    task automatic assert_reset();
        rst = 1'b1;
        for (int s = 0; s < c_SRC; s++) begin
            pend_q[s].delete();
            exp_q[s].delete();
        end
        #1;
        check_eq("rst_ready", 64'(v_src_ready), 64'd0);
        check_eq("rst_int_en", 64'(v_int_wr_en), 64'd0);
        check_eq("rst_fp_en", 64'(v_fp_wr_en), 64'd0);
        check_eq("rst_bus", 64'(v_wr_reg_index == '0 && v_wr_reg_data == '0), 64'd1);
        check_eq("rst_conflict", 64'(conflict_err), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        assert_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            #1;
            idle = queues_empty() && v_int_wr_en == '0 && v_fp_wr_en == '0;
        end
        check_eq("drain", 64'(idle), 64'd1);
    endtask

    initial begin
        int base;

        // Reset state and single-result latency.
        #12;
        check_eq("rst_ready_init", 64'(v_src_ready), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(v_src_ready), 64'hFFF);
        check_eq("post_rst_en", 64'(v_int_wr_en | v_fp_wr_en), 64'd0);
        pend_q[3].push_back(mk(1'b0, 5, 64'hDEAD));
        repeat (2) @(negedge clk);
        check_eq("t1_not_early", 64'(v_int_wr_en), 64'd0);
        @(negedge clk);
        check_eq("t1_int_en", 64'(v_int_wr_en), 64'h001);
        check_eq("t1_fp_en", 64'(v_fp_wr_en), 64'd0);
        check_eq("t1_idx", 64'(out_idx(0)), 64'd5);
        check_eq("t1_data", out_data(0), 64'hDEAD);
        wait_idle();

        // Full contention: two results per source from rr_ptr = 0.
        do_reset();
        @(negedge clk);
        for (int s = 0; s < c_SRC; s++) begin
            for (int j = 0; j < 2; j++) pend_q[s].push_back(mk(1'b0, 32 + s + 12*j, 64'h1000 + 64'(s*16 + j)));
        end
        repeat (3) @(negedge clk);
        check_eq("t2_c1_en", 64'(v_int_wr_en), 64'h3FF);
        for (int k = 0; k < c_EU; k++) check_eq("t2_c1_idx", 64'(out_idx(k)), 64'(32 + k));
        @(negedge clk);
        check_eq("t2_c2_en", 64'(v_int_wr_en), 64'h3FF);
        for (int k = 0; k < c_EU; k++) check_eq("t2_c2_idx", 64'(out_idx(k)), 64'(42 + k));
        @(negedge clk);
        check_eq("t2_c3_en", 64'(v_int_wr_en), 64'h00F);
        for (int k = 0; k < 4; k++) check_eq("t2_c3_idx", 64'(out_idx(k)), 64'(52 + k));
        wait_idle();

        // Backpressure on source 2: move rr_ptr to 4 so source 2 is skipped first.
        do_reset();
        @(negedge clk);
        pend_q[3].push_back(mk(1'b0, 1, 64'h33));
        wait_idle();
        seen_rdy2_low = 1'b0;
        base = delivered;
        @(negedge clk);
        for (int s = 0; s < c_SRC; s++) begin
            if (s == 2) begin
                pend_q[2].push_back(mk(1'b0, 9, 64'hA));
                pend_q[2].push_back(mk(1'b0, 9, 64'hB));
                pend_q[2].push_back(mk(1'b0, 9, 64'hC));
            end else begin
                for (int j = 0; j < 4; j++) pend_q[s].push_back(mk(1'b0, 60 + s, 64'h2000 + 64'(s*16 + j)));
            end
        end
        wait_idle();
        check_eq("t3_ready2_low", 64'(seen_rdy2_low), 64'd1);
        check_eq("t3_delivered", 64'(delivered - base), 64'd47);
        check_eq("t3_no_conflict", 64'(conflict_err), 64'd0);

        // Class mix: same index, different class is not a conflict.
        do_reset();
        @(negedge clk);
        pend_q[0].push_back(mk(1'b1, 7, 64'h70));
        pend_q[1].push_back(mk(1'b0, 7, 64'h71));
        repeat (3) @(negedge clk);
        check_eq("t4_fp_en", 64'(v_fp_wr_en), 64'h001);
        check_eq("t4_int_en", 64'(v_int_wr_en), 64'h002);
        check_eq("t4_idx0", 64'(out_idx(0)), 64'd7);
        check_eq("t4_idx1", 64'(out_idx(1)), 64'd7);
        check_eq("t4_conflict", 64'(conflict_err), 64'd0);
        wait_idle();

        // Same class, same index in one grant: sticky conflict, both writes issued.
        @(negedge clk);
        pend_q[4].push_back(mk(1'b0, 20, 64'h44));
        pend_q[6].push_back(mk(1'b0, 20, 64'h66));
        repeat (2) @(negedge clk);
        check_eq("t5_conflict_pre", 64'(conflict_err), 64'd0);
        @(negedge clk);
        check_eq("t5_conflict", 64'(conflict_err), 64'd1);
        check_eq("t5_int_en", 64'(v_int_wr_en), 64'h003);
        check_eq("t5_idx0", 64'(out_idx(0)), 64'd20);
        check_eq("t5_idx1", 64'(out_idx(1)), 64'd20);
        check_eq("t5_data0", out_data(0), 64'h44);
        wait_idle();
        check_eq("t5_conflict_sticky", 64'(conflict_err), 64'd1);

        // Reset while sources 10 and 11 hold full FIFOs.
        do_reset();
        check_eq("t6_conflict_clr", 64'(conflict_err), 64'd0);
        @(negedge clk);
        for (int s = 0; s < c_SRC; s++) begin
            for (int j = 0; j < 4; j++) pend_q[s].push_back(mk(1'b0, 60 + s, 64'h3000 + 64'(s*16 + j)));
        end
        repeat (3) @(posedge clk);
        #2;
        check_eq("t6_full_ready", 64'(v_src_ready), 64'h3FF);
        assert_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("t6_ready", 64'(v_src_ready), 64'hFFF);
            check_eq("t6_no_stale", 64'(v_int_wr_en | v_fp_wr_en), 64'd0);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
